// File: rtl/global_reset_pkg.sv
// Shared types and constants for the global reset sequencer.
package global_reset_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } seq_state_t;

    localparam int SYNC_STAGES = 2;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/reset_source_sync.sv
// Single-bit reset-request synchroniser; flops clear to 0 so a source reads as asserted during reset.
module reset_source_sync
    import global_reset_pkg::*;
#(
    parameter int DEPTH = SYNC_STAGES
) (
    input  logic clk,
    input  logic resetn,
    input  logic src,
    output logic sync
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], src};
        end
    end

    assign sync = chain[DEPTH-1];

endmodule

// File: rtl/global_reset_sequencer.sv
// Merges async reset sources, holds reset, then releases NUM_STAGES domains in order.
// Optional stuck-source watchdog enabled by `define RESET_SEQ_WATCHDOG_EN.
module global_reset_sequencer
    import global_reset_pkg::*;
#(
    parameter int RESET_SOURCES_WIDTH = 3,
    parameter int RESET_COUNTER_WIDTH = 8,
    parameter int NUM_STAGES          = 3,
    parameter int STAGE_DELAY_WIDTH   = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [RESET_SOURCES_WIDTH-1:0] resetn_sources,
    input  logic [RESET_SOURCES_WIDTH-1:0] source_mask,
    input  logic                           cause_clear,
    output logic [NUM_STAGES-1:0]          stage_resetn,
    output logic                           global_resetn,
    output logic [RESET_SOURCES_WIDTH-1:0] reset_cause,
    output logic                           busy,
    output logic                           source_stuck
);

    localparam int IDX_W = (clog2(NUM_STAGES) > 0) ? clog2(NUM_STAGES) : 1;

    logic [RESET_SOURCES_WIDTH-1:0] sync_src;
    logic                           fault;
    logic                           fault_q;
    seq_state_t                     state, state_next;
    logic [RESET_COUNTER_WIDTH-1:0] hold_cnt, hold_next;
    logic [STAGE_DELAY_WIDTH-1:0]   gap_cnt, gap_next;
    logic [IDX_W-1:0]               stage_idx, idx_next;
    logic [NUM_STAGES-1:0]          stage_next;
    logic                           busy_next;
    logic [RESET_SOURCES_WIDTH-1:0] cause_next;

    for (genvar i = 0; i < RESET_SOURCES_WIDTH; i++) begin : g_sync
        reset_source_sync u_sync (
            .clk    (clk),
            .resetn (resetn),
            .src    (resetn_sources[i]),
            .sync   (sync_src[i])
        );
    end

    assign fault = |(~sync_src & ~source_mask);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= HOLD;
            fault_q      <= 1'b1;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            stage_idx    <= '0;
            stage_resetn <= '0;
            busy         <= 1'b1;
            reset_cause  <= '0;
        end else begin
            state        <= state_next;
            fault_q      <= fault;
            hold_cnt     <= hold_next;
            gap_cnt      <= gap_next;
            stage_idx    <= idx_next;
            stage_resetn <= stage_next;
            busy         <= busy_next;
            reset_cause  <= cause_next;
        end
    end

    // The hold count only starts once the sources have been clean for a full registered cycle.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        gap_next   = gap_cnt;
        idx_next   = stage_idx;
        stage_next = stage_resetn;
        case (state)
            HOLD: begin
                stage_next = '0;
                if (fault || fault_q) begin
                    hold_next = '0;
                end else if (&hold_cnt) begin
                    stage_next[0] = 1'b1;
                    idx_next      = IDX_W'(1);
                    gap_next      = '0;
                    hold_next     = '0;
                    state_next    = (NUM_STAGES == 1) ? RUN : RELEASE;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (fault) begin
                    stage_next = '0;
                    hold_next  = '0;
                    state_next = HOLD;
                end else if (&gap_cnt) begin
                    stage_next[stage_idx] = 1'b1;
                    gap_next              = '0;
                    idx_next              = stage_idx + IDX_W'(1);
                    if (stage_idx == IDX_W'(NUM_STAGES - 1)) begin
                        state_next = RUN;
                    end
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            RUN: begin
                if (fault) begin
                    stage_next = '0;
                    hold_next  = '0;
                    state_next = HOLD;
                end else begin
                    stage_next = '1;
                end
            end
            default: begin
                stage_next = '0;
                hold_next  = '0;
                state_next = HOLD;
            end
        endcase
        busy_next  = (state_next != RUN);
        // A source still low on the clearing cycle keeps its bit set.
        cause_next = (reset_cause & ~{RESET_SOURCES_WIDTH{cause_clear}})
                   | (~sync_src & ~source_mask);
    end

    assign global_resetn = stage_resetn[NUM_STAGES-1];

`ifdef RESET_SEQ_WATCHDOG_EN
    logic [RESET_COUNTER_WIDTH+3:0] wd_cnt;
    logic                           stuck;
    logic                           wd_run;

    assign wd_run = (state == HOLD) && fault;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
            stuck  <= 1'b0;
        end else begin
            wd_cnt <= wd_run ? wd_cnt + 1'b1 : '0;
            if (wd_run && (&wd_cnt)) begin
                stuck <= 1'b1;
            end else if (cause_clear) begin
                stuck <= 1'b0;
            end
        end
    end

    assign source_stuck = stuck;
`else
    assign source_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_global_reset_sequencer.sv
// Directed bench for global_reset_sequencer: power-up, fault drop, hold restart, masking, cause, watchdog.
module tb_global_reset_sequencer;

    localparam int RSW      = 3;
    localparam int RCW      = 8;
    localparam int NS       = 3;
    localparam int SDW      = 4;
    localparam int HOLD_LAT = 2 + (1 << RCW) + 1;
    localparam int GAP      = 1 << SDW;
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic [RSW-1:0] resetn_sources;
    logic [RSW-1:0] source_mask;
    logic           cause_clear;
    logic [NS-1:0]  stage_resetn;
    logic           global_resetn;
    logic [RSW-1:0] reset_cause;
    logic           busy;
    logic           source_stuck;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    global_reset_sequencer #(
        .RESET_SOURCES_WIDTH (RSW),
        .RESET_COUNTER_WIDTH (RCW),
        .NUM_STAGES          (NS),
        .STAGE_DELAY_WIDTH   (SDW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .resetn_sources (resetn_sources),
        .source_mask    (source_mask),
        .cause_clear    (cause_clear),
        .stage_resetn   (stage_resetn),
        .global_resetn  (global_resetn),
        .reset_cause    (reset_cause),
        .busy           (busy),
        .source_stuck   (source_stuck)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts rising clock edges until the given stage is seen released, bounded by budget.
    task automatic count_until(input int idx, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (stage_resetn[idx]) break;
        end
    endtask

    task automatic pulse_clear();
        cause_clear = 1'b1;
        tick();
        cause_clear = 1'b0;
    endtask

    task automatic finish_sequence(input string pfx);
        int n;
        count_until(1, 64, n);
        check({pfx, "_gap1"}, n, GAP);
        check({pfx, "_stage01"}, stage_resetn, 3'b011);
        check({pfx, "_busy_mid"}, busy, 1'b1);
        count_until(2, 64, n);
        check({pfx, "_gap2"}, n, GAP);
        check({pfx, "_global"}, global_resetn, 1'b1);
        check({pfx, "_busy_run"}, busy, 1'b0);
    endtask

    // One-cycle low pulse on a source while in RUN, then re-hold timed from the source rising.
    task automatic drop_and_rehold(input int idx, input string pfx);
        int n;
        resetn_sources[idx] = 1'b0;
        tick();
        resetn_sources[idx] = 1'b1;
        tick();
        check({pfx, "_still_up_e2"}, stage_resetn, 3'b111);
        tick();
        check({pfx, "_down_e3"}, stage_resetn, 3'b000);
        check({pfx, "_global_down"}, global_resetn, 1'b0);
        check({pfx, "_busy_down"}, busy, 1'b1);
        count_until(0, 400, n);
        check({pfx, "_hold_lat"}, n + 2, HOLD_LAT);
        check({pfx, "_stage0_only"}, stage_resetn, 3'b001);
    endtask

    initial begin
        int n;
        resetn         = 1'b0;
        resetn_sources = '1;
        source_mask    = '0;
        cause_clear    = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_stage", stage_resetn, 3'b000);
        check("rst_global", global_resetn, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_cause", reset_cause, 3'b000);
        check("rst_stuck", source_stuck, 1'b0);

        // Power-up release; synchronisers come out of reset asserted, so every cause bit latches.
        resetn = 1'b1;
        count_until(0, 400, n);
        check("pwr_stage0_lat", n, HOLD_LAT);
        check("pwr_stage0_only", stage_resetn, 3'b001);
        finish_sequence("pwr");
        check("pwr_cause", reset_cause, 3'b111);
        pulse_clear();
        check("pwr_cause_clr", reset_cause, 3'b000);

        drop_and_rehold(1, "drop1");
        check("drop1_cause", reset_cause, 3'b010);
        finish_sequence("drop1");

        // Source 2 pulse, then a second glitch when hold_cnt has reached 200.
        resetn_sources[2] = 1'b0;
        tick();
        resetn_sources[2] = 1'b1;
        repeat (203) tick();
        check("glitch_still_held", stage_resetn, 3'b000);
        resetn_sources[2] = 1'b0;
        tick();
        resetn_sources[2] = 1'b1;
        count_until(0, 400, n);
        check("glitch_restart_lat", n, HOLD_LAT);
        check("glitch_cause", reset_cause, 3'b110);
        finish_sequence("glitch");

        source_mask       = 3'b001;
        resetn_sources[0] = 1'b0;
        repeat (4) tick();
        check("mask_stay_run", stage_resetn, 3'b111);
        check("mask_busy", busy, 1'b0);
        pulse_clear();
        check("mask_cause_clr", reset_cause, 3'b000);
        drop_and_rehold(1, "mask");
        finish_sequence("mask");
        check("mask_cause_bit0", reset_cause, 3'b010);

        source_mask = 3'b000;
        tick();
        check("unmask_down", stage_resetn, 3'b000);
        check("unmask_busy", busy, 1'b1);
        check("unmask_cause", reset_cause, 3'b011);
        pulse_clear();
        check("clr_set_wins", reset_cause, 3'b001);
        resetn_sources[0] = 1'b1;
        count_until(0, 400, n);
        check("unmask_hold_lat", n, HOLD_LAT);
        finish_sequence("unmask");
        pulse_clear();
        check("clr_after_release", reset_cause, 3'b000);

        // Asynchronous assertion mid-cycle while in RUN.
        resetn = 1'b0;
        #2;
        check("async_stage", stage_resetn, 3'b000);
        check("async_global", global_resetn, 1'b0);
        check("async_busy", busy, 1'b1);
        check("async_cause", reset_cause, 3'b000);
        @(negedge clk);
        resetn = 1'b1;
        count_until(0, 400, n);
        check("rst2_stage0_lat", n, HOLD_LAT);
        finish_sequence("rst2");

        resetn_sources[0] = 1'b0;
        repeat (4090) tick();
        check("wd_before_term", source_stuck, 1'b0);
        repeat (14) tick();
        check("wd_after_term", source_stuck, WD_EXP);
        check("wd_stage_low", stage_resetn, 3'b000);
        pulse_clear();
        check("wd_cleared", source_stuck, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
